// File: rtl/multiplier_4x4.sv
// multiplier_4x4: unsigned 4x4 array multiplier with a registered 8-bit product.
// Sixteen AND-gate partial products are reduced by three adder rows plus a
// final ripple stage (4 half adders, 8 full adders). The array result is
// captured on every rising clk edge, so the latency is one cycle.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  asynchronous active-high reset; clears product
//   inp1     in   4  multiplicand, unsigned
//   inp2     in   4  multiplier, unsigned
//   product  out  8  registered inp1*inp2

// half_adder: sum/carry of two bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// full_adder: sum/carry of three bits.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module multiplier_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] inp1,
  input  logic [3:0] inp2,
  output logic [7:0] product
);

  // pp[i][j] has weight i+j
  logic [3:0][3:0] pp;
  logic [7:0]      prod_c;

  always_comb begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        pp[i][j] = inp1[j] & inp2[i];
  end

  // Row 1: pp[0]>>1 + pp[1], weights 1..3
  logic s1b, s1c, c1a, c1b, c1c;
  half_adder ha1_w1 (.a(pp[0][1]), .b(pp[1][0]), .s(prod_c[1]), .c(c1a));
  half_adder ha1_w2 (.a(pp[0][2]), .b(pp[1][1]), .s(s1b),       .c(c1b));
  half_adder ha1_w3 (.a(pp[0][3]), .b(pp[1][2]), .s(s1c),       .c(c1c));

  // Row 2: add pp[2], weights 2..4 (pp[1][3] joins at weight 4)
  logic s2b, s2c, c2a, c2b, c2c;
  full_adder fa2_w2 (.a(pp[2][0]), .b(s1b),      .ci(c1a), .s(prod_c[2]), .co(c2a));
  full_adder fa2_w3 (.a(pp[2][1]), .b(s1c),      .ci(c1b), .s(s2b),       .co(c2b));
  full_adder fa2_w4 (.a(pp[2][2]), .b(pp[1][3]), .ci(c1c), .s(s2c),       .co(c2c));

  // Row 3: add pp[3], weights 3..5 (pp[2][3] joins at weight 5)
  logic s3b, s3c, c3a, c3b, c3c;
  full_adder fa3_w3 (.a(pp[3][0]), .b(s2b),      .ci(c2a), .s(prod_c[3]), .co(c3a));
  full_adder fa3_w4 (.a(pp[3][1]), .b(s2c),      .ci(c2b), .s(s3b),       .co(c3b));
  full_adder fa3_w5 (.a(pp[3][2]), .b(pp[2][3]), .ci(c2c), .s(s3c),       .co(c3c));

  // Final ripple, weights 4..7; the last carry-out is bit 7
  logic r4, r5;
  half_adder har_w4 (.a(s3b),      .b(c3a),                .s(prod_c[4]), .c(r4));
  full_adder far_w5 (.a(s3c),      .b(c3b), .ci(r4),       .s(prod_c[5]), .co(r5));
  full_adder far_w6 (.a(pp[3][3]), .b(c3c), .ci(r5),       .s(prod_c[6]), .co(prod_c[7]));

  assign prod_c[0] = pp[0][0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) product <= 8'h00;
    else     product <= prod_c;
  end

endmodule

// File: tb/tb_multiplier_4x4.sv
// tb_multiplier_4x4: directed checks of reset, latency, corners and an
// exhaustive sweep of the 4x4 multiplier.
module tb_multiplier_4x4;

  logic       clk;
  logic       rst;
  logic [3:0] inp1;
  logic [3:0] inp2;
  logic [7:0] product;

  int checks = 0;
  int errors = 0;

  multiplier_4x4 dut (
    .clk    (clk),
    .rst    (rst),
    .inp1   (inp1),
    .inp2   (inp2),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive operands between edges, then check one edge later.
  task automatic apply(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input string tag);
    @(negedge clk);
    inp1 = a;
    inp2 = b;
    @(posedge clk);
    #1 chk(tag, product, exp);
  endtask

  logic [7:0] wide;

  initial begin
    rst  = 1'b1;
    inp1 = 4'd15;
    inp2 = 4'd15;
    #1 chk("rst_async_init", product, 8'h00);
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", product, 8'h00);

    // release: first edge captures the operands
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("rst_release_15x15", product, 8'd225);

    apply(4'd10, 4'd12, 8'd120, "10x12");
    apply(4'd13, 4'd12, 8'd156, "13x12");
    apply(4'd12, 4'd15, 8'd180, "12x15");

    wide = 8'd22;
    apply(4'd10, wide[3:0], 8'd60, "trunc_10x22");
    apply(4'd11, wide[3:0], 8'd66, "trunc_11x22");

    apply(4'd0,  4'd13, 8'd0,   "0x13");
    apply(4'd13, 4'd0,  8'd0,   "13x0");
    apply(4'd1,  4'd9,  8'd9,   "1x9");
    apply(4'd15, 4'd15, 8'd225, "15x15");
    apply(4'd8,  4'd8,  8'd64,  "8x8");

    // back-to-back operands: each result appears exactly one edge later
    apply(4'd3, 4'd5, 8'd15, "pipe_3x5");
    @(negedge clk);
    inp1 = 4'd7;
    inp2 = 4'd9;
    #1 chk("pipe_hold_before_edge", product, 8'd15);
    @(posedge clk);
    #1 chk("pipe_7x9", product, 8'd63);
    apply(4'd14, 4'd2, 8'd28, "pipe_14x2");

    // async reset between edges
    #2 rst = 1'b1;
    #1 chk("rst_mid_async", product, 8'h00);
    @(posedge clk);
    #1 chk("rst_mid_hold", product, 8'h00);
    @(negedge clk);
    inp1 = 4'd6;
    inp2 = 4'd7;
    rst  = 1'b0;
    @(posedge clk);
    #1 chk("rst_mid_release_6x7", product, 8'd42);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        apply(4'(a), 4'(b), 8'(a * b), "exhaustive");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_4x4.md
Name: multiplier_4x4

Overview:
- Unsigned 4-bit x 4-bit array multiplier producing an 8-bit product.
- Built as a structural carry-save/ripple array of AND-gate partial products with half and full adders.
- The product is registered on the single clock, so the block drops into a synchronous datapath with one cycle of latency.
- Leaf arithmetic block; no handshake. The consumer samples `product` one cycle after presenting operands.

Parameters:
None. Operand width is fixed at 4 bits and product width at 8 bits.

Ports:
- clk      input   1  system clock; rising-edge active
- rst      input   1  asynchronous, active-high reset
- inp1     input   4  multiplicand, unsigned
- inp2     input   4  multiplier, unsigned
- product  output  8  registered unsigned product inp1*inp2

Behaviour:
- Clock/reset: one clock (`clk`). Reset `rst` is asynchronous and active-high.
  - `product` clears to 8'h00 immediately on `rst` assertion, independent of `clk`.
  - `product` holds 8'h00 while `rst` is high.
- Partial products: pp[i][j] = inp1[j] & inp2[i], for i,j in 0..3 (16 AND terms).
- Array reduction: three rows of adders, 4 half adders + 8 full adders total.
  - Row 1 adds pp[0] >> 1 to pp[1].
  - Rows 2 and 3 add pp[2] and pp[3] to the running sum/carry.
  - Final carries ripple into bit 7.
  - Half-adder and full-adder cells are separate leaf submodules inside the block, instantiated explicitly.
- Product bit 0 = pp[0][0], taken directly with no adder.
- Result register: the combinational array result is captured into `product` on every rising `clk` edge while `rst` is low.
  - Latency is exactly 1 cycle from operands stable before an edge to `product` valid after that edge.
  - Throughput is one multiply per cycle.
- Arithmetic:
  - Purely unsigned; no sign extension.
  - Maximum result is 15*15 = 225 (8'hE1). No overflow is possible and no overflow flag exists.
- Input width: operands are exactly 4 bits. Any wider value driven by the environment is truncated to its low 4 bits by port connection (e.g. 22 becomes 6). The block does no range checking.
- Inputs must be stable for setup/hold around the `clk` edge. There is no input register and no enable.
- Reset release: the first rising edge after `rst` falls captures the current operands. No extra warm-up cycle.
- Reset mid-operation: any in-flight result is discarded and `product` becomes 0 at once. The next product after release reflects the operands present at the first edge.
- Zero operand: either input 0 gives product 0 on the next edge.
- Output is glitch-free between edges because it comes straight from a flip-flop.

Test Plan:
- Reset check: assert `rst` with inp1=15, inp2=15 and toggle `clk` → `product` stays 8'h00. Release `rst`; the next rising edge → product=225.
- Basic values (rising edge between each pair, check one cycle later):
  - 10*12 → 120
  - 13*12 → 156
  - 12*15 → 180
- Truncation: drive inp2 with the low 4 bits of 22 (=6).
  - inp1=10 → 60
  - inp1=11 → 66
- Corners: 0*13 → 0; 1*9 → 9; 15*15 → 225; 8*8 → 64 (exercises the bit-6 carry path).
- Latency/async: change operands every cycle (3*5, 7*9, 14*2) → products 15, 63, 28 each appear exactly one edge later. Assert `rst` between edges → `product` goes 0 without waiting for `clk`.
- Exhaustive: all 256 operand pairs, one per cycle → product equals inp1*inp2 one cycle later in every case.
